jtag_cmd_parser: RTL

//  Byte-stream command parser between the JTAG UART streaming adapter and the
//  DSA core. Decodes host commands from rx bytes; performs image-memory

---
 rtl/jtag_cmd_parser.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/jtag_cmd_parser.sv
// jtag_cmd_parser: byte-stream command decoder sitting between the JTAG UART
// streaming adapter and the DSA core. Handles image-memory writes/reads,
// DSA start pulses and status queries, and returns reply bytes on tx.
//
// Handshake rules: a byte moves on a rising clk edge where valid && ready are
// both high. rx_ready depends only on the current state (IDLE/HDR/WDATA).
// tx_valid, once raised, stays high with tx_data unchanged until tx_ready.
// rx_ready and tx_valid are never high in the same cycle.
module jtag_cmd_parser #(
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    output logic              dsa_start,
    input  logic              dsa_busy,
    input  logic              dsa_done,
    output logic [3:0]        dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_HDR   = 4'd1,
        S_WDATA = 4'd2,
        S_WMEM  = 4'd3,
        S_RREQ  = 4'd4,
        S_RWAIT = 4'd5,
        S_RSEND = 4'd6,
        S_START = 4'd7,
        S_ACK   = 4'd8,
        S_STAT  = 4'd9,
        S_ERR   = 4'd10
    } state_t;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] OP_START = 8'h53;
    localparam logic [7:0] OP_STAT  = 8'h3F;
    localparam logic [7:0] RSP_ACK  = 8'h4B;
    localparam logic [7:0] RSP_ERR  = 8'h45;

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

    state_t           state_q, state_d;
    logic [1:0]       hdr_cnt_q, hdr_cnt_d;
    logic             is_write_q, is_write_d;
    logic [15:0]      addr_q, addr_d;
    logic [15:0]      len_q, len_d;
    logic [7:0]       wbyte_q, wbyte_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    logic        rx_ready_c;
    logic        tx_valid_c;
    logic        mem_we_c;
    logic        mem_re_c;
    logic        start_c;
    logic        rx_fire;
    logic        in_wait;
    logic        tmo_hit;
    logic [15:0] len_full;

    // State and datapath registers; reset abandons any command in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            hdr_cnt_q  <= 2'd0;
            is_write_q <= 1'b0;
            addr_q     <= 16'd0;
            len_q      <= 16'd0;
            wbyte_q    <= 8'd0;
            tx_byte_q  <= 8'd0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            hdr_cnt_q  <= hdr_cnt_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            wbyte_q    <= wbyte_d;
            tx_byte_q  <= tx_byte_d;
            tmo_q      <= tmo_d;
        end
    end

    // Next-state, datapath updates and strobes for the command FSM.
    always_comb begin
        state_d    = state_q;
        hdr_cnt_d  = hdr_cnt_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        len_d      = len_q;
        wbyte_d    = wbyte_q;
        tx_byte_d  = tx_byte_q;
        rx_ready_c = 1'b0;
        tx_valid_c = 1'b0;
        mem_we_c   = 1'b0;
        mem_re_c   = 1'b0;
        start_c    = 1'b0;
        len_full   = {len_q[7:0], rx_data};

        rx_ready_c = (state_q == S_IDLE) || (state_q == S_HDR) || (state_q == S_WDATA);
        rx_fire    = rx_valid && rx_ready_c;
        // The inter-byte timer only runs while a command is waiting for rx bytes.
        in_wait    = (state_q == S_HDR) || (state_q == S_WDATA);
        tmo_hit    = in_wait && !rx_fire && (tmo_q == TMO_LAST);
        tmo_d      = (!in_wait || rx_fire) ? '0 : tmo_q + TMO_ONE;

        case (state_q)
            S_IDLE: begin
                if (rx_fire) begin
                    hdr_cnt_d = 2'd0;
                    case (rx_data)
                        OP_WRITE: begin is_write_d = 1'b1; state_d = S_HDR; end
                        OP_READ:  begin is_write_d = 1'b0; state_d = S_HDR; end
                        OP_START: state_d = S_START;
                        OP_STAT: begin
                            tx_byte_d = {6'b0, dsa_busy, dsa_done};
                            state_d   = S_STAT;
                        end
                        default: begin
                            tx_byte_d = RSP_ERR;
                            state_d   = S_ERR;
                        end
                    endcase
                end
            end
            S_HDR: begin
                if (rx_fire) begin
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                    if (hdr_cnt_q[1] == 1'b0) begin
                        addr_d = {addr_q[7:0], rx_data};
                    end else begin
                        len_d = len_full;
                    end
                    if (hdr_cnt_q == 2'd3) begin
                        if (is_write_q) begin
                            if (len_full == 16'd0) begin
                                tx_byte_d = RSP_ACK;
                                state_d   = S_ACK;
                            end else begin
                                state_d = S_WDATA;
                            end
                        end else begin
                            state_d = (len_full == 16'd0) ? S_IDLE : S_RREQ;
                        end
                    end
                end else if (tmo_hit) begin
                    tx_byte_d = RSP_ERR;
                    state_d   = S_ERR;
                end
            end
            S_WDATA: begin
                if (rx_fire) begin
                    wbyte_d = rx_data;
                    state_d = S_WMEM;
                end else if (tmo_hit) begin
                    tx_byte_d = RSP_ERR;
                    state_d   = S_ERR;
                end
            end
            S_WMEM: begin
                mem_we_c = 1'b1;
                addr_d   = addr_q + 16'd1;
                len_d    = len_q - 16'd1;
                if (len_q == 16'd1) begin
                    tx_byte_d = RSP_ACK;
                    state_d   = S_ACK;
                end else begin
                    state_d = S_WDATA;
                end
            end
            S_RREQ: begin
                mem_re_c = 1'b1;
                state_d  = S_RWAIT;
            end
            S_RWAIT: begin
                tx_byte_d = mem_rdata;
                state_d   = S_RSEND;
            end
            S_RSEND: begin
                tx_valid_c = 1'b1;
                if (tx_ready) begin
                    addr_d  = addr_q + 16'd1;
                    len_d   = len_q - 16'd1;
                    state_d = (len_q == 16'd1) ? S_IDLE : S_RREQ;
                end
            end
            S_START: begin
                start_c   = 1'b1;
                tx_byte_d = RSP_ACK;
                state_d   = S_ACK;
            end
            S_ACK, S_STAT, S_ERR: begin
                tx_valid_c = 1'b1;
                if (tx_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are forced low outside the cycles that use them so reset shows all zeros.
    assign rx_ready  = rx_ready_c && !rst;
    assign tx_valid  = tx_valid_c;
    assign tx_data   = tx_valid_c ? tx_byte_q : 8'd0;
    assign mem_we    = mem_we_c;
    assign mem_re    = mem_re_c;
    assign mem_addr  = (mem_we_c || mem_re_c) ? addr_q[ADDR_W-1:0] : '0;
    assign mem_wdata = mem_we_c ? wbyte_q : 8'd0;
    assign dsa_start = start_c;
    assign dbg_state = state_q;

endmodule
